ddr_avalon_bridge: RTL and testbench
====================================

// Module: ddr_avalon_bridge
// PURPOSE
//  Memory-side responder for the ddr_if protocol: terminates the to_host end of
//  ddr_mux2 and drives the MiSTer DDRAM Avalon-MM burst port. Converts single-cycle
//  host read/write strobes into held Avalon requests. Returns read beats as rdata/
//  rdata_ready pulses. Reports busy until the transaction completes.
// PARAMETERS
//  ADDR_W   29  word address width (64-bit words)
//  DATA_W   64  data bus width
//  BURST_W  8   burst count width; read bursts of 1..255 beats
// PORTS
//  clk              in   1        system clock
//  reset            in   1        asynchronous, active-high reset
//  host             --   ddr_if   from_host modport; members below
//   .addr           in   ADDR_W   word address of the request
//   .wdata          in   DATA_W   write data, single beat
//   .byteenable     in   DATA_W/8 write byte enables
//   .burstcnt       in   BURST_W  read beat count; 0 is treated as 1
//   .read/.write    in   1        request strobe; valid only while busy=0
//   .acquire        in   1        arbitration hint; ignored by this block
//   .busy           out  1        high while a request is outstanding
//   .rdata          out  DATA_W   read beat data
//   .rdata_ready    out  1        one-cycle pulse per read beat
//  ddram_busy       in   1        Avalon waitrequest
//  ddram_dout       in   DATA_W   Avalon readdata
//  ddram_dout_ready in   1        Avalon readdatavalid
//  ddram_addr       out  ADDR_W   Avalon address
//  ddram_burstcnt   out  BURST_W  Avalon burstcount
//  ddram_din        out  DATA_W   Avalon writedata
//  ddram_be         out  DATA_W/8 Avalon byteenable
//  ddram_rd         out  1        Avalon read
//  ddram_we         out  1        Avalon write
// BEHAVIOUR
//  - All outputs are registered. Reset values: busy=1 during reset and 0 in the first
//    cycle after release; rd, we and rdata_ready = 0; addr, din, be and rdata = 0;
//    burstcnt=1; state=IDLE; beat counter=0.
//  - FSM states: IDLE, RD_REQ, RD_DATA, WR_REQ.
//  - IDLE: a request is accepted on a clock edge with busy=0 and read or write high.
//    On acceptance, addr, wdata, be and burstcnt are captured and busy=1 from the next
//    cycle on. If read and write are both high, the read is accepted and the write is
//    dropped.
//  - Read: the next state is RD_REQ. From the cycle after acceptance, rd=1 and
//    burstcnt=max(burstcnt,1). rd stays high until an edge with ddram_busy=0, then
//    the FSM moves to RD_DATA.
//  - RD_DATA: each ddram_dout_ready beat gives rdata=ddram_dout and rdata_ready=1 one
//    cycle later, and the beat counter decrements. When the last beat is returned,
//    busy=0 in the same cycle as the final rdata_ready, and the FSM returns to IDLE.
//  - Beats arriving in RD_REQ before the rd handshake completes are also counted.
//  - Write: the next state is WR_REQ. we=1 and burstcnt=1, with din and be held,
//    until an edge with ddram_busy=0. Then we=0, the FSM returns to IDLE, and busy=0
//    in the next cycle. A write's burstcnt input is ignored.
//  - Latency: strobe at edge N gives rd/we at N+1. A zero-wait read returns its first
//    rdata_ready at avalid+1.
//  - ddram_dout_ready in IDLE or WR_REQ is discarded: no rdata_ready, no state change.
//  - Strobes while busy=1 are ignored; no queueing.
//  - Reset mid-operation: everything returns to reset values immediately. Any
//    outstanding Avalon beats are discarded under the IDLE rule above.
//  - The beat counter is BURST_W wide and never underflows. Extra beats beyond
//    burstcnt are discarded.
// TESTING
//  - Single read: addr=0x100, burstcnt=1, no wait states, dout_ready one cycle after
//    rd with 0xDEAD -> rd high 1 cycle; rdata=0xDEAD with rdata_ready=1 for 1 cycle;
//    busy low on that same cycle.
//  - Burst read: burstcnt=4, waitrequest held 3 cycles, beats with gaps -> rd held 4
//    cycles with addr stable; 4 rdata_ready pulses in order; busy=0 with the 4th.
//  - Write: addr=0x20, wdata=0x1122, be=0x0F, waitrequest held 2 cycles -> we high 3
//    cycles, burstcnt=1, din/be stable; busy drops one cycle after we falls.
//  - Read and write strobed together with burstcnt=0 -> a read with burstcnt=1 is
//    issued, no we; a strobe while busy=1 produces no second request.
//  - Stray beat in IDLE, and a 5th beat after a burstcnt=4 read -> no rdata_ready for
//    either; FSM stays in IDLE.
//  - Reset asserted in RD_DATA after 2 of 4 beats -> rd/we/rdata_ready cleared
//    immediately; late beats ignored; a new read after release completes normally.

Source files
------------

// File: rtl/ddr_avalon_bridge_if.sv
// ddr_if: host-side request/response bundle of the DDR port.
//
// Handshake: a request is one cycle of read or write (with addr, wdata,
// byteenable and burstcnt valid in that cycle) presented while busy is low.
// busy doubles as the inverted ready: while it is high, strobes are dropped,
// not queued. Read data returns as one rdata_ready pulse per beat, with no
// back-pressure from the host.
//
// Members:
//   addr        word address (64-bit words)
//   wdata       single-beat write data
//   byteenable  write byte enables
//   burstcnt    read beat count, 0 behaves as 1
//   read/write  request strobes
//   acquire     arbitration hint from the host side
//   busy        request outstanding
//   rdata       read beat data
//   rdata_ready one-cycle pulse per returned beat
// Modports: from_host (memory-side responder), to_host (requester).
interface ddr_if #(
  parameter int ADDR_W  = 29,
  parameter int DATA_W  = 64,
  parameter int BURST_W = 8
);
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] byteenable;
  logic [BURST_W-1:0]  burstcnt;
  logic                read;
  logic                write;
  logic                acquire;
  logic                busy;
  logic [DATA_W-1:0]   rdata;
  logic                rdata_ready;

  modport from_host (
    input  addr, wdata, byteenable, burstcnt, read, write, acquire,
    output busy, rdata, rdata_ready
  );

  modport to_host (
    output addr, wdata, byteenable, burstcnt, read, write, acquire,
    input  busy, rdata, rdata_ready
  );
endinterface

// File: rtl/ddr_avalon_bridge.sv
// ddr_avalon_bridge: memory-side responder of ddr_if driving an Avalon-MM
// burst port. Single-cycle host strobes become Avalon requests held until
// waitrequest drops; read beats are forwarded as rdata/rdata_ready pulses.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   host              ddr_if.from_host request/response bundle
//   ddram_busy        Avalon waitrequest
//   ddram_dout        Avalon readdata
//   ddram_dout_ready  Avalon readdatavalid
//   ddram_addr        Avalon address
//   ddram_burstcnt    Avalon burstcount
//   ddram_din         Avalon writedata
//   ddram_be          Avalon byteenable
//   ddram_rd/we       Avalon read/write
//   dbg_state         current FSM state (IDLE=0, RD_REQ=1, RD_DATA=2, WR_REQ=3)
module ddr_avalon_bridge #(
  parameter int ADDR_W  = 29,
  parameter int DATA_W  = 64,
  parameter int BURST_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  ddr_if.from_host            host,
  input  logic                ddram_busy,
  input  logic [DATA_W-1:0]   ddram_dout,
  input  logic                ddram_dout_ready,
  output logic [ADDR_W-1:0]   ddram_addr,
  output logic [BURST_W-1:0]  ddram_burstcnt,
  output logic [DATA_W-1:0]   ddram_din,
  output logic [DATA_W/8-1:0] ddram_be,
  output logic                ddram_rd,
  output logic                ddram_we,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_DATA = 2'd2,
    WR_REQ  = 2'd3
  } state_t;

  state_t             state;
  logic [BURST_W-1:0] beat_cnt;
  logic [BURST_W-1:0] req_len;
  logic [BURST_W-1:0] cnt_after;
  logic               beat_take;
  logic               unused_acquire;

  // The arbitration hint matters only to the mux upstream.
  assign unused_acquire = host.acquire;

  assign req_len   = (host.burstcnt == '0) ? BURST_W'(1) : host.burstcnt;
  // A zero counter swallows surplus beats, so the counter never wraps.
  assign beat_take = ddram_dout_ready && (beat_cnt != '0);
  assign cnt_after = beat_take ? beat_cnt - BURST_W'(1) : beat_cnt;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      beat_cnt         <= '0;
      host.busy        <= 1'b1;
      host.rdata       <= '0;
      host.rdata_ready <= 1'b0;
      ddram_addr       <= '0;
      ddram_burstcnt   <= BURST_W'(1);
      ddram_din        <= '0;
      ddram_be         <= '0;
      ddram_rd         <= 1'b0;
      ddram_we         <= 1'b0;
    end else begin
      host.rdata_ready <= 1'b0;
      case (state)
        IDLE: begin
          host.busy <= 1'b0;
          // busy is the registered flag, so a strobe in the cycle busy is
          // still high (e.g. right after a write) is ignored.
          if (!host.busy && (host.read || host.write)) begin
            ddram_addr <= host.addr;
            ddram_din  <= host.wdata;
            ddram_be   <= host.byteenable;
            host.busy  <= 1'b1;
            if (host.read) begin
              ddram_burstcnt <= req_len;
              beat_cnt       <= req_len;
              ddram_rd       <= 1'b1;
              state          <= RD_REQ;
            end else begin
              ddram_burstcnt <= BURST_W'(1);
              ddram_we       <= 1'b1;
              state          <= WR_REQ;
            end
          end
        end

        RD_REQ: begin
          if (beat_take) begin
            host.rdata       <= ddram_dout;
            host.rdata_ready <= 1'b1;
            beat_cnt         <= cnt_after;
          end
          if (!ddram_busy) begin
            ddram_rd <= 1'b0;
            // All beats may already be in if they raced the command accept.
            if (cnt_after == '0) begin
              host.busy <= 1'b0;
              state     <= IDLE;
            end else begin
              state <= RD_DATA;
            end
          end
        end

        RD_DATA: begin
          if (beat_take) begin
            host.rdata       <= ddram_dout;
            host.rdata_ready <= 1'b1;
            beat_cnt         <= cnt_after;
          end
          // busy falls together with the final rdata_ready pulse.
          if (cnt_after == '0) begin
            host.busy <= 1'b0;
            state     <= IDLE;
          end
        end

        WR_REQ: begin
          // busy is released one cycle later, from IDLE.
          if (!ddram_busy) begin
            ddram_we <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_avalon_bridge.sv
module tb_ddr_avalon_bridge;
  localparam int AW  = 29;
  localparam int DW  = 64;
  localparam int BW  = 8;
  localparam int BEW = DW / 8;

  typedef struct packed {
    logic           wr;
    logic [AW-1:0]  addr;
    logic [BW-1:0]  bc;
    logic [DW-1:0]  din;
    logic [BEW-1:0] be;
  } req_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ddr_if #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) host ();

  logic           ddram_busy;
  logic [DW-1:0]  ddram_dout;
  logic           ddram_dout_ready;
  logic [AW-1:0]  ddram_addr;
  logic [BW-1:0]  ddram_burstcnt;
  logic [DW-1:0]  ddram_din;
  logic [BEW-1:0] ddram_be;
  logic           ddram_rd;
  logic           ddram_we;
  logic [1:0]     dbg_state;

  ddr_avalon_bridge #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) dut (
    .clk              (clk),
    .reset            (reset),
    .host             (host),
    .ddram_busy       (ddram_busy),
    .ddram_dout       (ddram_dout),
    .ddram_dout_ready (ddram_dout_ready),
    .ddram_addr       (ddram_addr),
    .ddram_burstcnt   (ddram_burstcnt),
    .ddram_din        (ddram_din),
    .ddram_be         (ddram_be),
    .ddram_rd         (ddram_rd),
    .ddram_we         (ddram_we),
    .dbg_state        (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int beats_seen = 0;
  logic [DW:0]   exp_q[$];      // {last beat of transaction, data}
  req_t          req_q[$];      // expected Avalon requests, in order
  logic [DW-1:0] pend_q[$];     // beats the memory still has to return
  logic [DW-1:0] ref_mem   [logic [AW-1:0]];
  logic [DW-1:0] slave_mem [logic [AW-1:0]];
  int forced_wait = -1;         // -1: random waitrequest length
  bit gaps = 1'b1;              // random idle cycles between beats
  int stray_n = 0;              // unsolicited beats to inject

  function automatic logic [DW-1:0] seed_word(input logic [AW-1:0] a);
    logic [31:0] a32;
    a32 = 32'(a);
    return {32'hC0DE_0000 ^ a32, a32 * 32'h9E37_79B1};
  endfunction

  function automatic logic [DW-1:0] merge_be(input logic [DW-1:0] old,
                                             input logic [DW-1:0] d,
                                             input logic [BEW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BEW; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] ref_word(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
  endfunction

  function automatic logic [DW-1:0] slave_word(input logic [AW-1:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : seed_word(a);
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (host.busy && k < 2000) begin
      cycle(1);
      k++;
    end
    check("busy_release_timeout", DW'(host.busy), '0);
  endtask

  // One host request; the reference model records what the Avalon side and
  // the read-return path should show for it.
  task automatic host_req(input bit rd, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BEW-1:0] be,
                          input logic [BW-1:0] bc);
    int n;
    wait_idle();
    host.read = rd;  host.write = wr;  host.addr = a;  host.wdata = d;
    host.byteenable = be;  host.burstcnt = bc;
    host.acquire = 1'($urandom_range(0, 1));
    if (rd) begin
      n = (bc == 0) ? 1 : int'(bc);
      req_q.push_back('{wr: 1'b0, addr: a, bc: BW'(n), din: d, be: be});
      for (int i = 0; i < n; i++)
        exp_q.push_back({(i == n - 1), ref_word(a + AW'(i))});
    end else if (wr) begin
      req_q.push_back('{wr: 1'b1, addr: a, bc: BW'(1), din: d, be: be});
      ref_mem[a] = merge_be(ref_word(a), d, be);
    end
    cycle(1);
    host.read = 1'b0;
    host.write = 1'b0;
    check("req_issue", DW'({ddram_rd, ddram_we}), DW'({rd, wr & ~rd}));
    check("busy_after_accept", DW'(host.busy), DW'(1));
  endtask

  task automatic inject_stray();
    int k;
    stray_n = 1;
    k = 0;
    while (stray_n > 0 && k < 100) begin
      cycle(1);
      k++;
    end
    cycle(3);
    check("stray_sent", DW'(stray_n), '0);
    check("idle_after_stray", DW'(dbg_state), '0);
    check("busy_after_stray", DW'(host.busy), '0);
  endtask

  // ---------------- Avalon memory model ----------------
  initial begin : avalon_slave
    req_t h;
    bit   active;
    int   wait_left;
    int   post_hs;
    bit   post_wr;
    int   n;
    active = 1'b0;  wait_left = 0;  post_hs = 0;  post_wr = 1'b0;
    ddram_busy = 1'b1;  ddram_dout = '0;  ddram_dout_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      // The cycle after a handshake the request must be gone; a write's
      // busy releases one cycle after that.
      if (post_hs == 1) begin
        check("post_hs_rd", DW'(ddram_rd), '0);
        check("post_hs_we", DW'(ddram_we), '0);
        check("post_hs_busy", DW'(host.busy), DW'(1));
        post_hs = post_wr ? 2 : 0;
      end else if (post_hs == 2) begin
        check("wr_busy_release", DW'(host.busy), '0);
        post_hs = 0;
      end

      ddram_dout_ready = 1'b0;
      if (pend_q.size() > 0) begin
        if (!gaps || $urandom_range(0, 3) != 0) begin
          ddram_dout = pend_q.pop_front();
          ddram_dout_ready = 1'b1;
        end
      end else if (stray_n > 0 && !ddram_rd) begin
        ddram_dout = 64'hBAD0_BAD0_BAD0_BAD0;
        ddram_dout_ready = 1'b1;
        stray_n--;
      end

      ddram_busy = 1'($urandom_range(0, 1));
      if (ddram_rd || ddram_we) begin
        if (!active) begin
          active = 1'b1;
          wait_left = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 3));
        end
        if (req_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_request: got rd=%0b we=%0b addr=0x%0h want none",
                   ddram_rd, ddram_we, ddram_addr);
        end else begin
          h = req_q[0];
          check("avl_rd", DW'(ddram_rd), DW'(!h.wr));
          check("avl_we", DW'(ddram_we), DW'(h.wr));
          check("avl_addr", DW'(ddram_addr), DW'(h.addr));
          check("avl_burstcnt", DW'(ddram_burstcnt), DW'(h.bc));
          if (h.wr) begin
            check("avl_din", ddram_din, h.din);
            check("avl_be", DW'(ddram_be), DW'(h.be));
          end
        end
        if (wait_left > 0) begin
          ddram_busy = 1'b1;
          wait_left--;
        end else begin
          ddram_busy = 1'b0;
          active = 1'b0;
          post_hs = 1;
          post_wr = ddram_we;
          if (req_q.size() > 0) void'(req_q.pop_front());
          if (ddram_rd) begin
            n = (ddram_burstcnt == 0) ? 1 : int'(ddram_burstcnt);
            for (int i = 0; i < n; i++) pend_q.push_back(slave_word(ddram_addr + AW'(i)));
          end else begin
            slave_mem[ddram_addr] = merge_be(slave_word(ddram_addr), ddram_din, ddram_be);
          end
        end
      end
    end
  end

  // ---------------- read-return monitor ----------------
  initial begin : rdata_monitor
    logic [DW:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (host.rdata_ready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rdata_ready: got 0x%0h want no beat", host.rdata);
        end else begin
          e = exp_q.pop_front();
          check("rdata", host.rdata, e[DW-1:0]);
          check("busy_on_beat", DW'(host.busy), DW'(!e[DW]));
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int k;
    int b0;
    int kind;
    host.read = 1'b0;  host.write = 1'b0;  host.addr = '0;  host.wdata = '0;
    host.byteenable = '0;  host.burstcnt = '0;  host.acquire = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", DW'(host.busy), DW'(1));
    check("rst_rd_we", DW'({ddram_rd, ddram_we}), '0);
    check("rst_rdata_ready", DW'(host.rdata_ready), '0);
    check("rst_rdata", host.rdata, '0);
    check("rst_addr", DW'(ddram_addr), '0);
    check("rst_din", ddram_din, '0);
    check("rst_be", DW'(ddram_be), '0);
    check("rst_burstcnt", DW'(ddram_burstcnt), DW'(1));
    check("rst_state", DW'(dbg_state), '0);
    #2 reset = 1'b0;
    cycle(1);
    check("busy_first_cycle", DW'(host.busy), '0);

    // Single zero-wait read returning 0xDEAD.
    slave_mem[AW'('h100)] = 64'hDEAD;
    ref_mem[AW'('h100)]   = 64'hDEAD;
    forced_wait = 0;  gaps = 1'b0;
    host_req(1'b1, 1'b0, AW'('h100), '0, '0, BW'(1));
    wait_idle();

    // Burst of 4 with 3 wait states and gappy beats.
    forced_wait = 3;  gaps = 1'b1;
    host_req(1'b1, 1'b0, AW'('h200), '0, '0, BW'(4));
    wait_idle();

    // Write with 2 wait states; its burstcnt input must be ignored.
    forced_wait = 2;
    host_req(1'b0, 1'b1, AW'('h20), 64'h1122, 8'h0F, BW'(9));
    wait_idle();
    forced_wait = 0;
    host_req(1'b1, 1'b0, AW'('h1F), '0, '0, BW'(3));
    wait_idle();

    // Read and write together with burstcnt 0, then a strobe while busy.
    forced_wait = 2;
    host_req(1'b1, 1'b1, AW'('h30), 64'h55, 8'hFF, BW'(0));
    host.write = 1'b1;
    host.addr = AW'('h31);
    cycle(1);
    host.write = 1'b0;
    check("no_second_request", DW'(ddram_we), '0);
    wait_idle();

    // Stray beat in IDLE, then a 5th beat after a 4-beat read.
    forced_wait = 0;
    inject_stray();
    host_req(1'b1, 1'b0, AW'('h40), '0, '0, BW'(4));
    wait_idle();
    inject_stray();

    // Reset in RD_DATA after 2 of 4 beats.
    b0 = beats_seen;
    host_req(1'b1, 1'b0, AW'('h300), '0, '0, BW'(4));
    k = 0;
    while (beats_seen < b0 + 2 && k < 500) begin
      @(posedge clk);
      #2;
      k++;
    end
    check("beats_before_reset", DW'(beats_seen - b0), DW'(2));
    #1 reset = 1'b1;
    #1;
    check("midrst_rd_we", DW'({ddram_rd, ddram_we}), '0);
    check("midrst_rdata_ready", DW'(host.rdata_ready), '0);
    check("midrst_busy", DW'(host.busy), DW'(1));
    check("midrst_state", DW'(dbg_state), '0);
    exp_q.delete();
    req_q.delete();
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    cycle(1);
    check("busy_after_release", DW'(host.busy), '0);
    k = 0;
    while (pend_q.size() > 0 && k < 100) begin
      cycle(1);
      k++;
    end
    cycle(2);
    check("stale_beats_drained", DW'(pend_q.size()), '0);
    check("idle_after_stale", DW'(dbg_state), '0);
    host_req(1'b1, 1'b0, AW'('h300), '0, '0, BW'(4));
    wait_idle();

    // Randomized traffic over a small address window so reads see writes.
    forced_wait = -1;
    for (int t = 0; t < 60; t++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 5)
        host_req(1'b1, 1'b0, AW'($urandom_range(0, 63)), '0, '0, BW'($urandom_range(0, 8)));
      else if (kind < 9)
        host_req(1'b0, 1'b1, AW'($urandom_range(0, 63)), {$urandom, $urandom},
                 BEW'($urandom_range(0, 255)), BW'($urandom_range(0, 255)));
      else
        host_req(1'b1, 1'b1, AW'($urandom_range(0, 63)), {$urandom, $urandom},
                 BEW'($urandom_range(0, 255)), BW'($urandom_range(0, 3)));
    end
    host_req(1'b1, 1'b0, AW'('h1000), '0, '0, BW'(255));
    wait_idle();

    cycle(10);
    check("exp_q_drained", DW'(exp_q.size()), '0);
    check("req_q_drained", DW'(req_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    bad++;
    $display("FAIL watchdog: got no end of test want finish before 1ms");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
